// File: rtl/ham_pkg.sv
// Shared state encoding and width helpers for the Hamming min/max engine.
package ham_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, CMP, WB, DONE} ham_state_t;

    // Distance width: enough bits to hold the value WORD_W itself.
    function automatic int dw_f(input int word_w);
        return $clog2(word_w + 1);
    endfunction

    function automatic int iw_f(input int n_words);
        return (n_words > 2) ? $clog2(n_words) : 1;
    endfunction

endpackage

// File: rtl/ham_popcount.sv
// Combinational Hamming distance: popcount of the XOR of two operands.
module ham_popcount
    import ham_pkg::*;
#(
    parameter  int WORD_W = 16,
    localparam int DW     = dw_f(WORD_W)
) (
    input  logic [WORD_W-1:0] a_i,
    input  logic [WORD_W-1:0] b_i,
    output logic [DW-1:0]     dist_o
);

    logic [WORD_W-1:0] diff;

    assign diff = a_i ^ b_i;

    always_comb begin
        dist_o = '0;
        for (int i = 0; i < WORD_W; i++) begin
            dist_o = dist_o + DW'(diff[i]);
        end
    end

endmodule

// File: rtl/hamming_minmax_engine.sv
// Scans N_WORDS big-endian operands from byte memory, finds min/max pairwise Hamming distance.
// Define HAM_PAIR_WB_EN to also write the four pair indices back after the two distances.
module hamming_minmax_engine
    import ham_pkg::*;
#(
    parameter  int WORD_W   = 16,
    parameter  int N_WORDS  = 32,
    parameter  int ADDR_W   = 8,
    parameter  int RES_BASE = 64,
    localparam int DW       = dw_f(WORD_W),
    localparam int IW       = iw_f(N_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [7:0]        mem_wdata,
    output logic [DW-1:0]     min_dist,
    output logic [DW-1:0]     max_dist,
    output logic [IW-1:0]     min_lo,
    output logic [IW-1:0]     min_hi,
    output logic [IW-1:0]     max_lo,
    output logic [IW-1:0]     max_hi
);

    localparam int B      = WORD_W / 8;
    localparam int NBYTES = N_WORDS * B;
    localparam int BW     = (B > 1) ? $clog2(B) : 1;
`ifdef HAM_PAIR_WB_EN
    localparam int WB_N   = 6;
`else
    localparam int WB_N   = 2;
`endif

    ham_state_t        state_q, state_d;
    logic              start_q, done_q;
    logic [ADDR_W-1:0] addr_q;
    logic [BW-1:0]     b_q;
    logic [IW-1:0]     j_q, k_q;
    logic [2:0]        wb_q;
    logic [DW-1:0]     min_q, max_q, pair_dist;
    logic [IW-1:0]     min_lo_q, min_hi_q, max_lo_q, max_hi_q;
    logic [WORD_W-1:0] cache_q [N_WORDS];
    logic              launch, load_last, cmp_last, wb_last;

    assign launch    = start_q && !start;
    assign load_last = (addr_q == ADDR_W'(NBYTES - 1));
    assign cmp_last  = (j_q == IW'(N_WORDS - 2)) && (k_q == IW'(N_WORDS - 1));
    assign wb_last   = (wb_q == 3'(WB_N - 1));

    ham_popcount #(.WORD_W(WORD_W)) u_popcount (
        .a_i    (cache_q[j_q]),
        .b_i    (cache_q[k_q]),
        .dist_o (pair_dist)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (launch) state_d = LOAD;
            LOAD:    if (start) state_d = IDLE; else if (load_last) state_d = CMP;
            CMP:     if (start) state_d = IDLE; else if (cmp_last)  state_d = WB;
            WB:      if (start) state_d = IDLE; else if (wb_last)   state_d = DONE;
            DONE:    if (start) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = (state_q == LOAD) ? addr_q : '0;
        mem_wen   = (state_q == WB) && !start;
        mem_waddr = '0;
        mem_wdata = '0;
        if (state_q == WB) begin
            mem_waddr = ADDR_W'(RES_BASE) + ADDR_W'(wb_q);
            case (wb_q)
                3'd0:    mem_wdata = 8'(min_q);
                3'd1:    mem_wdata = 8'(max_q);
`ifdef HAM_PAIR_WB_EN
                3'd2:    mem_wdata = 8'(min_lo_q);
                3'd3:    mem_wdata = 8'(min_hi_q);
                3'd4:    mem_wdata = 8'(max_lo_q);
                3'd5:    mem_wdata = 8'(max_hi_q);
`endif
                default: mem_wdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            b_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            wb_q     <= '0;
            min_q    <= DW'(WORD_W);
            max_q    <= '0;
            min_lo_q <= '0;
            min_hi_q <= '0;
            max_lo_q <= '0;
            max_hi_q <= '0;
        end else begin
            start_q <= start;
            done_q  <= (state_q == DONE);
            case (state_q)
                IDLE: if (launch) begin
                    min_q  <= DW'(WORD_W);
                    max_q  <= '0;
                    addr_q <= '0;
                    b_q    <= '0;
                    j_q    <= '0;
                end
                LOAD: if (!start) begin
                    addr_q <= addr_q + 1'b1;
                    if (b_q == BW'(B - 1)) begin
                        b_q <= '0;
                        j_q <= j_q + 1'b1;
                    end else begin
                        b_q <= b_q + 1'b1;
                    end
                    if (load_last) begin
                        j_q <= '0;
                        k_q <= IW'(1);
                    end
                end
                CMP: if (!start) begin
                    // Strict compares keep the first pair in scan order on ties.
                    if (pair_dist < min_q) begin
                        min_q    <= pair_dist;
                        min_lo_q <= j_q;
                        min_hi_q <= k_q;
                    end
                    if (pair_dist > max_q) begin
                        max_q    <= pair_dist;
                        max_lo_q <= j_q;
                        max_hi_q <= k_q;
                    end
                    if (k_q == IW'(N_WORDS - 1)) begin
                        j_q <= j_q + 1'b1;
                        k_q <= j_q + IW'(2);
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                    wb_q <= '0;
                end
                WB:      wb_q <= wb_q + 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the operand cache has no reset; LOAD rewrites every word before CMP reads it.
    always_ff @(posedge clk) begin
        if (state_q == LOAD && !start) begin
            cache_q[j_q] <= (cache_q[j_q] << 8) | WORD_W'(mem_rdata);
        end
    end

    assign done     = done_q;
    assign min_dist = min_q;
    assign max_dist = max_q;
    assign min_lo   = min_lo_q;
    assign min_hi   = min_hi_q;
    assign max_lo   = max_lo_q;
    assign max_hi   = max_hi_q;

endmodule
